// File: rtl/mdu_hilo_if.sv
// Pipeline/multiplier-facing bundle for the MDU front end and HI/LO register file.
interface mdu_hilo_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_z;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, flush, mul_z,
        input  mul_a, mul_b, busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, flush, mul_z,
        output mul_a, mul_b, busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_hilo.sv
// MDU front end: operand magnitude conversion, multicycle hold, sign fix-up and HI/LO commit.
// Optional MADD/MADDU accumulate is enabled by defining MDU_MADD_EN.
module mdu_hilo #(
    parameter int MUL_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    mdu_hilo_if.slave  bus
);
    typedef enum logic {IDLE, MUL} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        neg;
    logic        is_mul;
    logic        is_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] prod;
    logic [63:0] result;
`ifdef MDU_MADD_EN
    logic        acc;
`endif

    always_comb begin
        is_signed = bus.op[0];
        case (bus.op)
            3'b000, 3'b001: is_mul = 1'b1;
`ifdef MDU_MADD_EN
            3'b100, 3'b101: is_mul = 1'b1;
`endif
            default:        is_mul = 1'b0;
        endcase
        // 0x8000_0000 negates to itself, which is the correct unsigned magnitude.
        mag_a = (is_signed && bus.rs_data[31]) ? (32'd0 - bus.rs_data) : bus.rs_data;
        mag_b = (is_signed && bus.rt_data[31]) ? (32'd0 - bus.rt_data) : bus.rt_data;
        prod  = neg ? (64'd0 - bus.mul_z) : bus.mul_z;
`ifdef MDU_MADD_EN
        result = acc ? ({bus.hi, bus.lo} + prod) : prod;
`else
        result = prod;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            neg       <= 1'b0;
`ifdef MDU_MADD_EN
            acc       <= 1'b0;
`endif
            bus.mul_a <= '0;
            bus.mul_b <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.hi    <= '0;
            bus.lo    <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        if (bus.op == 3'b010) begin
                            bus.hi <= bus.rs_data;
                        end else if (bus.op == 3'b011) begin
                            bus.lo <= bus.rs_data;
                        end else if (is_mul) begin
                            bus.mul_a <= mag_a;
                            bus.mul_b <= mag_b;
                            neg       <= is_signed & (bus.rs_data[31] ^ bus.rt_data[31]);
`ifdef MDU_MADD_EN
                            acc       <= bus.op[2];
`endif
                            cnt       <= 4'(MUL_CYCLES);
                            bus.busy  <= 1'b1;
                            state     <= MUL;
                        end
                    end
                end
                MUL: begin
                    // Flush wins over a commit landing on the same edge.
                    if (bus.flush) begin
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else if (cnt == 4'd1) begin
                        {bus.hi, bus.lo} <= result;
                        cnt      <= '0;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo with a transaction-level reference model and per-cycle compare.
module tb_mdu_hilo;
    localparam int MUL_CYCLES = 2;
`ifdef MDU_MADD_EN
    localparam bit MADD_ON = 1'b1;
`else
    localparam bit MADD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_hilo_if bus();
    mdu_hilo #(.MUL_CYCLES(MUL_CYCLES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // The bench plays the combinational unsigned multiplier.
    assign bus.mul_z = {32'd0, bus.mul_a} * {32'd0, bus.mul_b};

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: tracks an outstanding multiply as a due-cycle count and a precomputed result.
    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic [63:0] m_res;
    bit          m_busy, m_done, m_acc;
    int          m_left;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
            m_busy = 0; m_done = 0; m_acc = 0; m_left = 0; m_res = '0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                if (bus.flush) begin
                    m_busy = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        {m_hi, m_lo} = m_acc ? ({m_hi, m_lo} + m_res) : m_res;
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end else if (bus.start && !bus.flush) begin
                if (bus.op == 3'd2) m_hi = bus.rs_data;
                else if (bus.op == 3'd3) m_lo = bus.rs_data;
                else if (bus.op == 3'd0 || bus.op == 3'd1 ||
                         (MADD_ON && (bus.op == 3'd4 || bus.op == 3'd5))) begin
                    if (bus.op[0]) begin
                        m_res = 64'(longint'($signed(bus.rs_data)) * longint'($signed(bus.rt_data)));
                        m_a = bus.rs_data[31] ? -bus.rs_data : bus.rs_data;
                        m_b = bus.rt_data[31] ? -bus.rt_data : bus.rt_data;
                    end else begin
                        m_res = {32'd0, bus.rs_data} * {32'd0, bus.rt_data};
                        m_a = bus.rs_data;
                        m_b = bus.rt_data;
                    end
                    m_acc  = bus.op[2];
                    m_left = MUL_CYCLES;
                    m_busy = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  {63'd0, bus.busy}, {63'd0, m_busy});
            check("done",  {63'd0, bus.done}, {63'd0, m_done});
            check("hi",    {32'd0, bus.hi},   {32'd0, m_hi});
            check("lo",    {32'd0, bus.lo},   {32'd0, m_lo});
            check("mul_a", {32'd0, bus.mul_a}, {32'd0, m_a});
            check("mul_b", {32'd0, bus.mul_b}, {32'd0, m_b});
        end
    end

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit expect_done);
        int busy_cycles = 0;
        int dones = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < (expect_done ? 20 : MUL_CYCLES + 2); i++) begin
            if (i > 0) @(negedge clk);
            if (bus.busy) busy_cycles++;
            if (bus.done) dones++;
            if (expect_done && dones > 0) break;
        end
        check({name, " done count"}, 64'(dones), {63'd0, expect_done});
        check({name, " busy cycles"}, 64'(busy_cycles), expect_done ? 64'(MUL_CYCLES) : 64'd0);
        $display("op %-8s a=%h b=%h -> hi=%h lo=%h", name, a, b, bus.hi, bus.lo);
    endtask

    initial begin
        logic [31:0] save_hi, save_lo;
        int dones;
        bus.start = 1'b0; bus.op = 3'd0; bus.rs_data = '0; bus.rt_data = '0; bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset hi", {32'd0, bus.hi}, 64'd0);
        check("reset busy", {63'd0, bus.busy}, 64'd0);
        rst_n = 1'b1;

        run_op("MULTU", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("multu hi", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFE);
        check("multu lo", {32'd0, bus.lo}, 64'h0000_0000_0000_0001);

        run_op("MULT", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
        check("mult mul_a", {32'd0, bus.mul_a}, 64'd2);
        check("mult mul_b", {32'd0, bus.mul_b}, 64'd3);
        check("mult hi", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFF);
        check("mult lo", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFFA);

        run_op("MULTmin", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
        check("min mul_a", {32'd0, bus.mul_a}, 64'h0000_0000_8000_0000);
        check("min hi", {32'd0, bus.hi}, 64'h0000_0000_4000_0000);
        check("min lo", {32'd0, bus.lo}, 64'd0);

        run_op("MTHI", 3'd2, 32'h1234_5678, 32'd0, 1'b0);
        run_op("MTLO", 3'd3, 32'h9ABC_DEF0, 32'd0, 1'b0);
        check("mthi hi", {32'd0, bus.hi}, 64'h0000_0000_1234_5678);
        check("mtlo lo", {32'd0, bus.lo}, 64'h0000_0000_9ABC_DEF0);

        run_op("MADDU", 3'd4, 32'd2, 32'd3, MADD_ON);
        check("maddu hi", {32'd0, bus.hi}, 64'h0000_0000_1234_5678);
        check("maddu lo", {32'd0, bus.lo}, MADD_ON ? 64'h0000_0000_9ABC_DEF6 : 64'h0000_0000_9ABC_DEF0);

        // Flush in the first busy cycle.
        save_hi = bus.hi; save_lo = bus.lo;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.rs_data = 32'd5; bus.rt_data = 32'd7;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", {63'd0, bus.busy}, 64'd0);
        dones = 0;
        repeat (4) begin @(negedge clk); if (bus.done) dones++; end
        check("flush dones", 64'(dones), 64'd0);
        check("flush hi", {32'd0, bus.hi}, {32'd0, save_hi});
        check("flush lo", {32'd0, bus.lo}, {32'd0, save_lo});
        $display("op FLUSH    a=00000005 b=00000007 -> hi=%h lo=%h", bus.hi, bus.lo);

        // Reset while a multiply is in flight.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.rs_data = 32'd9; bus.rt_data = 32'd9;
        @(negedge clk);
        bus.start = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst hi", {32'd0, bus.hi}, 64'd0);
        check("rst lo", {32'd0, bus.lo}, 64'd0);
        check("rst mul_a", {32'd0, bus.mul_a}, 64'd0);
        check("rst busy", {63'd0, bus.busy}, 64'd0);
        dones = 0;
        repeat (4) begin @(negedge clk); if (bus.done) dones++; end
        check("rst dones", 64'(dones), 64'd0);
        check("rst no commit", {32'd0, bus.lo}, 64'd0);
        $display("op RESET    a=00000009 b=00000009 -> hi=%h lo=%h", bus.hi, bus.lo);

        // A start pulse during busy must be dropped.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.rs_data = 32'd3; bus.rt_data = 32'd4;
        @(negedge clk);
        bus.op = 3'd2; bus.rs_data = 32'h0000_DEAD;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        if (bus.done) dones++;
        repeat (5) begin @(negedge clk); if (bus.done) dones++; end
        check("busy-start dones", 64'(dones), 64'd1);
        check("busy-start hi", {32'd0, bus.hi}, 64'd0);
        check("busy-start lo", {32'd0, bus.lo}, 64'd12);
        $display("op IGNORED  a=00000003 b=00000004 -> hi=%h lo=%h", bus.hi, bus.lo);

        run_op("MADD", 3'd5, 32'hFFFF_FFFE, 32'd3, MADD_ON);
        check("madd hi", {32'd0, bus.hi}, 64'd0);
        check("madd lo", {32'd0, bus.lo}, MADD_ON ? 64'd6 : 64'd12);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multiply/divide-unit front end and HI/LO register file for the MIPS CPU execute stage. It accepts multiply and HI/LO-move requests from the pipeline and converts signed operands to magnitudes for the downstream combinational unsigned 32x32 multiplier. It holds the operands stable for a fixed multicycle window, sign-corrects the 64-bit product, and commits the result into HI/LO. While a multiply is in flight it raises `busy` so the pipeline stalls.

## Interface
Parameters:
- `MUL_CYCLES`, default 2. Cycles from request accept to HI/LO commit. Legal range 1..15. Sets the multicycle path budget for the multiplier.

Ports:
- `clk`, in, 1. Single clock. All state changes on the rising edge.
- `rst_n`, in, 1. Reset is synchronous and active-low.
- `start`, in, 1. Request valid. Sampled only when `busy`=0.
- `op`, in, 3. Operation code: 000 MULTU, 001 MULT, 010 MTHI, 011 MTLO, 100 MADDU, 101 MADD. Other codes are no-ops.
- `rs_data`, in, 32. Operand A, or the source value for MTHI/MTLO.
- `rt_data`, in, 32. Operand B.
- `flush`, in, 1. Pipeline exception flush. Aborts an in-flight multiply.
- `mul_a`, out, 32. Magnitude of A, driven to the multiplier.
- `mul_b`, out, 32. Magnitude of B, driven to the multiplier.
- `mul_z`, in, 64. Unsigned product returned from the multiplier.
- `busy`, out, 1. Multiply in flight. The pipeline must stall on it.
- `done`, out, 1. One-cycle pulse in the cycle the new HI/LO are first visible.
- `hi`, out, 32. HI register (MFHI source).
- `lo`, out, 32. LO register (MFLO source).

## Operation
- States: IDLE, MUL.
- Reset (`rst_n`=0 at an edge) forces: state IDLE; `hi`, `lo`, `mul_a`, `mul_b` = 0; `busy` = 0; `done` = 0; counter = 0; sign and accumulate flags = 0.
- IDLE, `start`=1, MTHI: `hi` ← `rs_data` at that edge. MTLO does the same for `lo`. Both are single-cycle; `busy` stays 0.
- IDLE, `start`=1, multiply op, `flush`=0, at the accept edge:
  - `mul_a`/`mul_b` are registered. For signed ops, a negative operand is two's-complement negated, so 0x8000_0000 gives magnitude 0x8000_0000. Unsigned ops pass operands through.
  - `neg` ← `rs_data[31]` ^ `rt_data[31]` for signed ops, otherwise 0.
  - Accumulate flag set for MADD/MADDU.
  - Counter ← `MUL_CYCLES`; go to MUL.
- MUL:
  - Counter decrements each edge.
  - At the edge where counter = 1: compute P = `neg` ? (0 − `mul_z`) mod 2^64 : `mul_z`.
  - {`hi`,`lo`} ← P, or ← {`hi`,`lo`} + P mod 2^64 when accumulating.
  - Same edge: `done` ← 1 and return to IDLE.
- `mul_a`/`mul_b` hold constant for the whole MUL state.
- Reset mid-MUL: result is discarded and every output takes its reset value.
- `flush`=1 during MUL: return to IDLE at that edge, no commit, `hi`/`lo` unchanged, no `done`.
- `flush`=1 together with `start` in IDLE: request is ignored.
- `start` while `busy`=1: ignored. The pipeline guarantees the request is held until accepted.

## Timing
- Accept edge at T. `busy`=1 in cycles T+1 .. T+`MUL_CYCLES`.
- New `hi`/`lo` and `done`=1 are visible in cycle T+`MUL_CYCLES`+1, in which `busy`=0.
- A new request can be accepted at the edge closing cycle T+`MUL_CYCLES`+1. Back-to-back throughput is one multiply per `MUL_CYCLES`+1 cycles.
- The multiplier path `mul_a`/`mul_b` → `mul_z` is a multicycle path of `MUL_CYCLES` cycles.
- MTHI/MTLO accepted at T are visible at T+1.
- `done` is never asserted for MTHI/MTLO.

## Configuration
- `MDU_MADD_EN` defined: MADDU (100) and MADD (101) accumulate into HI/LO as described.
- `MDU_MADD_EN` undefined: codes 100/101 are no-ops (no `busy`, no change to `hi`/`lo`), and the 64-bit accumulate adder is not built.

## Test plan
- Reset, then MULTU 0xFFFF_FFFF × 0xFFFF_FFFF with `MUL_CYCLES`=2 → `busy` high for 2 cycles, then `hi`=0xFFFF_FFFE, `lo`=0x0000_0001, `done` pulse for 1 cycle.
- MULT 0xFFFF_FFFE (−2) × 0x0000_0003 → `mul_a`=2, `mul_b`=3, then `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFFA. MULT 0x8000_0000 × 0x8000_0000 → `hi`=0x4000_0000, `lo`=0.
- MTHI 0x1234_5678, then MTLO 0x9ABC_DEF0 → visible next cycle, `busy` never asserted. MADDU 2×3 (macro on) → `hi`=0x1234_5678, `lo`=0x9ABC_DEF6.
- MULTU 5×7, assert `flush` in the first `busy` cycle → IDLE next cycle, `hi`/`lo` unchanged, no `done`.
- `rst_n`=0 mid-MUL → `hi`=`lo`=`mul_a`=`mul_b`=0, `busy`=0, and no commit afterwards. `start` pulses while `busy` are ignored: exactly one `done` per accepted op.
- Macro off: MADD 2×3 → no `busy`, `hi`/`lo` unchanged.
